// File: rtl/mag_cook_sequencer.sv
// Cook-cycle controller for the magnetron path: cook-time countdown on a 1 Hz
// strobe, door interlock, pause/resume, end-of-cook hold and power duty window.
module mag_cook_sequencer #(
    parameter int TIME_W     = 12,
    parameter int DONE_TICKS = 3,
    parameter int CYCLE      = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              TICK,
    input  logic              DOOR_CLOSED,
    input  logic              START,
    input  logic              STOP_CLEAR,
    input  logic              LOAD,
    input  logic [TIME_W-1:0] TIME_IN,
    input  logic [3:0]        POWER_IN,
    output logic              MAG_ON,
    output logic [TIME_W-1:0] TIME_LEFT,
    output logic [1:0]        STATE,
    output logic              DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int                DC_W      = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
    localparam logic [3:0]        CYCLE_P   = 4'(CYCLE);
    localparam logic [3:0]        LAST_PH   = 4'(CYCLE - 1);
    localparam logic [DC_W-1:0]   DONE_LAST = DC_W'(DONE_TICKS - 1);
    localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);
    localparam logic [TIME_W-1:0] TIME_ZERO = TIME_W'(0);

    // Out-of-range power requests (0 or above the window length) mean full power.
    function automatic logic [3:0] clamp_power(input logic [3:0] p);
        if ((p == 4'd0) || (p > CYCLE_P)) begin
            clamp_power = CYCLE_P;
        end else begin
            clamp_power = p;
        end
    endfunction

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [3:0]          power_q, power_d;
    logic [3:0]          phase_q, phase_d;
    logic [DC_W-1:0]     done_cnt_q, done_cnt_d;
    logic                mag_q, mag_d;
    logic                done_q, done_d;

    // Next-state and datapath decode for the cook sequencer.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        power_d    = power_q;
        phase_d    = phase_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (STOP_CLEAR) begin
                    time_d = TIME_ZERO;
                end else if (LOAD) begin
                    time_d  = TIME_IN;
                    power_d = clamp_power(POWER_IN);
                end else if (START && DOOR_CLOSED && (time_q != TIME_ZERO)) begin
                    state_d = ST_COOK;
                    phase_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COOK: begin
                if (!DOOR_CLOSED || STOP_CLEAR) begin
                    state_d = ST_PAUSE;
                end else if (TICK) begin
                    phase_d = (phase_q >= LAST_PH) ? 4'd0 : (phase_q + 4'd1);
                    // A count of 0 here is unreachable; treat it like 1 so it can never wrap.
                    if (time_q <= TIME_ONE) begin
                        time_d     = TIME_ZERO;
                        state_d    = ST_DONE;
                        done_cnt_d = '0;
                    end else begin
                        time_d = time_q - TIME_ONE;
                    end
                end else begin
                    state_d = ST_COOK;
                end
            end
            ST_PAUSE: begin
                if (STOP_CLEAR) begin
                    state_d = ST_IDLE;
                    time_d  = TIME_ZERO;
                end else if (START && DOOR_CLOSED) begin
                    state_d = ST_COOK;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (STOP_CLEAR) begin
                    state_d    = ST_IDLE;
                    done_cnt_d = '0;
                end else if (LOAD) begin
                    state_d    = ST_IDLE;
                    done_cnt_d = '0;
                    time_d     = TIME_IN;
                    power_d    = clamp_power(POWER_IN);
                end else if (TICK) begin
                    if (done_cnt_q >= DONE_LAST) begin
                        state_d    = ST_IDLE;
                        done_cnt_d = '0;
                    end else begin
                        done_cnt_d = done_cnt_q + DC_W'(1);
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                time_d     = TIME_ZERO;
                power_d    = CYCLE_P;
                phase_d    = 4'd0;
                done_cnt_d = '0;
            end
        endcase
    end

    // Registered output decode from the next state.
    always_comb begin
        mag_d  = (state_d == ST_COOK) && (phase_d < power_d);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset aborts any cook at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            time_q     <= TIME_ZERO;
            power_q    <= CYCLE_P;
            phase_q    <= 4'd0;
            done_cnt_q <= '0;
            mag_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            power_q    <= power_d;
            phase_q    <= phase_d;
            done_cnt_q <= done_cnt_d;
            mag_q      <= mag_d;
            done_q     <= done_d;
        end
    end

    // The door gate is deliberately combinational so an opening door cuts power instantly.
    assign MAG_ON    = mag_q & DOOR_CLOSED;
    assign TIME_LEFT = time_q;
    assign STATE     = state_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_mag_cook_sequencer.sv
// Self-checking bench for mag_cook_sequencer: vector table plus hand sequences,
// with expectations queued at drive time and compared after the clock edge.
module tb_mag_cook_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        TICK = 1'b0, DOOR_CLOSED = 1'b1, START = 1'b0, STOP_CLEAR = 1'b0, LOAD = 1'b0;
    logic [11:0] TIME_IN = 12'd0;
    logic [3:0]  POWER_IN = 4'd0;
    logic        MAG_ON;
    logic [11:0] TIME_LEFT;
    logic [1:0]  STATE;
    logic        DONE;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        door, start, stop, load, tick;
        logic [11:0] tin;
        logic [3:0]  pin;
        logic [1:0]  es;
        logic [11:0] et;
        logic        em, ed;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [11:0] tl;
        logic        mag, dn;
        string       nm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[14];

    mag_cook_sequencer #(.TIME_W(12), .DONE_TICKS(3), .CYCLE(10)) dut (
        .CLK(CLK), .RST_N(RST_N), .TICK(TICK), .DOOR_CLOSED(DOOR_CLOSED),
        .START(START), .STOP_CLEAR(STOP_CLEAR), .LOAD(LOAD),
        .TIME_IN(TIME_IN), .POWER_IN(POWER_IN),
        .MAG_ON(MAG_ON), .TIME_LEFT(TIME_LEFT), .STATE(STATE), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic door, st, sp, ld, tk, input logic [11:0] tin,
                         input logic [3:0] pin, input logic [1:0] es, input logic [11:0] et,
                         input logic em, ed, input string nm);
        exp_t e;
        @(negedge CLK);
        DOOR_CLOSED = door; START = st; STOP_CLEAR = sp; LOAD = ld; TICK = tk;
        TIME_IN = tin; POWER_IN = pin;
        e.st = es; e.tl = et; e.mag = em; e.dn = ed; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic settle();
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow actual=0 required=1");
        end else begin
            e = sb.pop_front();
            chk({e.nm, ".STATE"}, 32'(STATE), 32'(e.st));
            chk({e.nm, ".TIME_LEFT"}, 32'(TIME_LEFT), 32'(e.tl));
            chk({e.nm, ".MAG_ON"}, 32'(MAG_ON), 32'(e.mag));
            chk({e.nm, ".DONE"}, 32'(DONE), 32'(e.dn));
        end
        START = 1'b0; STOP_CLEAR = 1'b0; LOAD = 1'b0; TICK = 1'b0;
    endtask

    task automatic cyc(input logic door, st, sp, ld, tk, input logic [11:0] tin,
                       input logic [3:0] pin, input logic [1:0] es, input logic [11:0] et,
                       input logic em, ed, input string nm);
        drive(door, st, sp, ld, tk, tin, pin, es, et, em, ed, nm);
        settle();
    endtask

    initial begin
        logic [3:0] pw[3];
        // {door, start, stop, load, tick, tin, pin, state, time, mag, done}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd5, 4'd3, 2'd0, 12'd5, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd1, 12'd5, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd4, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd1, 12'd4, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd3, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd2, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd3, 12'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd3, 12'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd3, 12'd0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd7, 4'd5, 2'd0, 12'd7, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'd9, 4'd2, 2'd0, 12'd0, 1'b0, 1'b0};

        // Power-on reset state.
        repeat (3) @(posedge CLK);
        #1;
        chk("por.STATE", 32'(STATE), 32'd0);
        chk("por.TIME_LEFT", 32'(TIME_LEFT), 32'd0);
        chk("por.MAG_ON", 32'(MAG_ON), 32'd0);
        chk("por.DONE", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Basic cook at power 3, DONE hold, and IDLE simultaneous-event rules.
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].door, tbl[i].start, tbl[i].stop, tbl[i].load, tbl[i].tick,
                tbl[i].tin, tbl[i].pin, tbl[i].es, tbl[i].et, tbl[i].em, tbl[i].ed,
                $sformatf("tbl%0d", i));
        end

        // Door interlock with phase retention across the pause.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd22, 4'd3, 2'd0, 12'd22, 1'b0, 1'b0, "door.load");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd1, 12'd22, 1'b1, 1'b0, "door.start");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd21, 1'b1, 1'b0, "door.tick1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd20, 1'b1, 1'b0, "door.tick2");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd2, 12'd20, 1'b0, 1'b0, "door.open");
        #1;
        chk("door.open_pre_edge.MAG_ON", 32'(MAG_ON), 32'd0);
        chk("door.open_pre_edge.STATE", 32'(STATE), 32'd1);
        settle();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd2, 12'd20, 1'b0, 1'b0, "door.start_open");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd2, 12'd20, 1'b0, 1'b0, "door.closed");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd1, 12'd20, 1'b1, 1'b0, "door.resume");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd19, 1'b0, 1'b0, "door.phase3");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 4'd0, 2'd2, 12'd19, 1'b0, 1'b0, "door.stop1");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b0, "door.stop2");

        // Stop/clear: pause, tick ignored in pause, clear, start with zero time ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd40, 4'd10, 2'd0, 12'd40, 1'b0, 1'b0, "stop.load");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd1, 12'd40, 1'b1, 1'b0, "stop.start");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 4'd0, 2'd2, 12'd40, 1'b0, 1'b0, "stop.pause");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd2, 12'd40, 1'b0, 1'b0, "stop.tick_pause");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b0, "stop.clear");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b0, "stop.start_ign");

        // Power clamping: 0, 15 and 10 all give continuous power over a 12 s cook.
        pw[0] = 4'd0; pw[1] = 4'd15; pw[2] = 4'd10;
        for (int p = 0; p < 3; p++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd12, pw[p], 2'd0, 12'd12, 1'b0, 1'b0,
                $sformatf("pw%0d.load", pw[p]));
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd1, 12'd12, 1'b1, 1'b0,
                $sformatf("pw%0d.start", pw[p]));
            for (int t = 1; t <= 11; t++) begin
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'(12 - t), 1'b1, 1'b0,
                    $sformatf("pw%0d.tick%0d", pw[p], t));
                if (t == 5) begin
                    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd99, 4'd1, 2'd1, 12'd7, 1'b1, 1'b0,
                        $sformatf("pw%0d.load_in_cook", pw[p]));
                end
            end
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd3, 12'd0, 1'b0, 1'b1,
                $sformatf("pw%0d.done", pw[p]));
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b0,
                $sformatf("pw%0d.clear", pw[p]));
        end

        // Asynchronous reset in the middle of a cook.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd30, 4'd5, 2'd0, 12'd30, 1'b0, 1'b0, "rst.load");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd1, 12'd30, 1'b1, 1'b0, "rst.start");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 4'd0, 2'd1, 12'd29, 1'b1, 1'b0, "rst.tick");
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_async.STATE", 32'(STATE), 32'd0);
        chk("rst_async.TIME_LEFT", 32'(TIME_LEFT), 32'd0);
        chk("rst_async.MAG_ON", 32'(MAG_ON), 32'd0);
        chk("rst_async.DONE", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b0, "rst.start_after");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
